// File: rtl/wisc_alu16_pkg.sv
// Shared opcode encodings for the WISC 16-bit ALU.
package wisc_alu16_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_XOR    = 4'd2;
   localparam logic [3:0] OP_RED    = 4'd3;
   localparam logic [3:0] OP_SLL    = 4'd4;
   localparam logic [3:0] OP_SRA    = 4'd5;
   localparam logic [3:0] OP_ROR    = 4'd6;
   localparam logic [3:0] OP_PADDSB = 4'd7;
   localparam logic [3:0] OP_LW     = 4'd8;
   localparam logic [3:0] OP_SW     = 4'd9;
   localparam logic [3:0] OP_LHB    = 4'd10;
   localparam logic [3:0] OP_LLB    = 4'd11;

endpackage

// File: rtl/wisc_alu16_sat_adder.sv
// Width-parameterised two's complement adder/subtractor with saturated,
// raw (wrapping) result and a signed-overflow indication.
module sat_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sat,
   output logic [W-1:0] raw,
   output logic         ovf
);

   logic [W-1:0] bx;

   // Subtraction is a + ~b + 1, so overflow is judged against the inverted operand.
   assign bx  = sub ? ~b : b;
   assign raw = a + bx + {{(W-1){1'b0}}, sub};
   assign ovf = (a[W-1] == bx[W-1]) && (raw[W-1] != a[W-1]);

   always_comb begin
      sat = raw;
      if (ovf) begin
         sat = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/wisc_alu16.sv
// 16-bit WISC ALU: combinational result plus a Z/N/V flag register
// updated on the clock for flag-setting operations.
module wisc_alu16
   import wisc_alu16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  ALUControl,
   output logic [15:0] out,
   output logic        zFlag,
   output logic        nFlag,
   output logic        vFlag
);

   logic [15:0] add_sat;
   logic [15:0] add_raw;
   logic        add_ovf;
   logic [15:0] pd_sat;
   logic [15:0] pd_raw_unused;
   logic [3:0]  pd_ovf_unused;
   logic [9:0]  red_s;
   logic [15:0] sll_r;
   logic [15:0] sra_r;
   logic [15:0] ror_r;

   sat_adder #(.W(16)) u_add (
      .a   (a),
      .b   (b),
      .sub (ALUControl == OP_SUB),
      .sat (add_sat),
      .raw (add_raw),
      .ovf (add_ovf)
   );

   for (genvar i = 0; i < 4; i++) begin : g_nib
      sat_adder #(.W(4)) u_nib (
         .a   (a[4*i +: 4]),
         .b   (b[4*i +: 4]),
         .sub (1'b0),
         .sat (pd_sat[4*i +: 4]),
         .raw (pd_raw_unused[4*i +: 4]),
         .ovf (pd_ovf_unused[i])
      );
   end

   // Four signed bytes summed at 10 bits can never overflow, so no saturation is needed.
   assign red_s = {{2{a[15]}}, a[15:8]} + {{2{b[15]}}, b[15:8]}
                + {{2{a[7]}}, a[7:0]} + {{2{b[7]}}, b[7:0]};

   assign sll_r = a << b[3:0];
   assign sra_r = $signed(a) >>> b[3:0];
   // A left shift by 16 clears to zero, so rotate-by-0 reduces to plain a.
   assign ror_r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));

   always_comb begin
      out = 16'h0000;
      case (ALUControl)
         OP_ADD, OP_SUB: out = add_sat;
         OP_XOR:         out = a ^ b;
         OP_RED:         out = {{6{red_s[9]}}, red_s};
         OP_SLL:         out = sll_r;
         OP_SRA:         out = sra_r;
         OP_ROR:         out = ror_r;
         OP_PADDSB:      out = pd_sat;
         OP_LW, OP_SW:   out = add_raw;
         OP_LHB:         out = {b[7:0], a[7:0]};
         OP_LLB:         out = {a[15:8], b[7:0]};
         default:        out = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zFlag <= 1'b0;
         nFlag <= 1'b0;
         vFlag <= 1'b0;
      end else begin
         case (ALUControl)
            OP_ADD, OP_SUB: begin
               zFlag <= (add_sat == 16'h0000);
               nFlag <= add_sat[15];
               vFlag <= add_ovf;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
               zFlag <= (out == 16'h0000);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wisc_alu16.sv
// Randomised and directed scoreboard bench for wisc_alu16 against an
// arithmetic reference model of the opcode rules.
module tb_wisc_alu16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic [3:0]  alu_ctrl = 4'd12;
   logic [15:0] out;
   logic        zflag, nflag, vflag;

   int checks = 0;
   int errors = 0;

   // Entries are {out, z, n, v} expected after the posedge following the drive.
   logic [18:0] exp_q[$];
   logic        mz = 1'b0, mn = 1'b0, mv = 1'b0;
   logic [15:0] corners[6];

   wisc_alu16 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .ALUControl (alu_ctrl),
      .out        (out),
      .zFlag      (zflag),
      .nFlag      (nflag),
      .vFlag      (vflag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void model_calc(input logic [3:0] o, input logic [15:0] x,
                                      input logic [15:0] y, output logic [15:0] r,
                                      output logic ovf);
      int s, sx, sy, sh, p1, p2, p3, p4;
      sx  = $signed(x);
      sy  = $signed(y);
      sh  = int'(y[3:0]);
      r   = 16'h0000;
      ovf = 1'b0;
      case (o)
         4'd0, 4'd1: begin
            s = (o == 4'd0) ? sx + sy : sx - sy;
            if (s > 32767) begin
               r = 16'h7FFF; ovf = 1'b1;
            end else if (s < -32768) begin
               r = 16'h8000; ovf = 1'b1;
            end else begin
               r = s[15:0];
            end
         end
         4'd2: r = x ^ y;
         4'd3: begin
            p1 = $signed(x[15:8]); p2 = $signed(y[15:8]);
            p3 = $signed(x[7:0]);  p4 = $signed(y[7:0]);
            s = p1 + p2 + p3 + p4;
            r = s[15:0];
         end
         4'd4: r = x << sh;
         4'd5: begin
            s = sx >>> sh;
            r = s[15:0];
         end
         4'd6: begin
            r = x;
            repeat (sh) r = {r[0], r[15:1]};
         end
         4'd7: begin
            for (int i = 0; i < 4; i++) begin
               p1 = $signed(x[4*i +: 4]);
               p2 = $signed(y[4*i +: 4]);
               s = p1 + p2;
               if (s > 7) s = 7;
               if (s < -8) s = -8;
               r[4*i +: 4] = s[3:0];
            end
         end
         4'd8, 4'd9: r = x + y;
         4'd10: r = {y[7:0], x[7:0]};
         4'd11: r = {x[15:8], y[7:0]};
         default: r = 16'h0000;
      endcase
   endfunction

   task automatic model_flags(input logic [3:0] o, input logic [15:0] r, input logic ovf);
      if (o <= 4'd1) begin
         mz = (r == 16'h0000); mn = r[15]; mv = ovf;
      end else if (o == 4'd2 || o == 4'd4 || o == 4'd5 || o == 4'd6) begin
         mz = (r == 16'h0000);
      end
   endtask

   task automatic do_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [15:0] r;
      logic        ovf;
      @(negedge clk);
      alu_ctrl = o;
      a = x;
      b = y;
      model_calc(o, x, y, r, ovf);
      model_flags(o, r, ovf);
      exp_q.push_back({r, mz, mn, mv});
   endtask

   task automatic idle();
      @(negedge clk);
      alu_ctrl = 4'd12;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d entries left expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: out and flags are stable one step after each active edge.
   initial begin
      logic [18:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out", out, e[18:3]);
            check("flags_znv", {13'd0, zflag, nflag, vflag}, {13'd0, e[2:0]});
         end
      end
   end

   initial begin
      logic [15:0] r;
      logic        ovf;
      logic [15:0] x, y;
      logic [3:0]  o;
      corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8080};

      #12;
      check("reset_flags", {13'd0, zflag, nflag, vflag}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(4'd10, 16'h042E, 16'h13A0);
      do_op(4'd11, 16'h042E, 16'h13A0);
      do_op(4'd0, 16'h7FFF, 16'h0001);
      do_op(4'd0, 16'h8000, 16'hFFFF);
      do_op(4'd0, 16'h8000, 16'h8000);
      do_op(4'd1, 16'h0000, 16'h8000);
      do_op(4'd1, 16'h0005, 16'h0005);
      do_op(4'd2, 16'h0005, 16'h0002);
      for (int k = 4; k <= 6; k++) begin
         do_op(4'(k), 16'h8001, 16'h0001);
         do_op(4'(k), 16'h8001, 16'h0000);
         do_op(4'(k), 16'hB6E3, 16'h000F);
      end
      do_op(4'd7, 16'h1234, 16'h1111);
      do_op(4'd7, 16'h7878, 16'h1818);
      do_op(4'd3, 16'h0101, 16'h0101);
      do_op(4'd3, 16'h8080, 16'h8080);
      do_op(4'd8, 16'hFFFF, 16'h0002);
      do_op(4'd9, 16'h7FFF, 16'h0001);
      do_op(4'd13, 16'h1234, 16'h5678);
      idle();
      drain();

      // Asynchronous reset between edges must clear flags without touching out.
      do_op(4'd0, 16'h7FFF, 16'h0001);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_calc(4'd0, 16'h7FFF, 16'h0001, r, ovf);
      check("async_reset_flags", {13'd0, zflag, nflag, vflag}, 16'h0000);
      check("async_reset_out", out, r);
      mz = 1'b0; mn = 1'b0; mv = 1'b0;
      alu_ctrl = 4'd12;
      @(negedge clk);
      rst_n = 1'b1;

      repeat (40) begin
         o = 4'($urandom_range(0, 15));
         x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         do_op(o, x, y);
      end
      idle();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
